// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Optional feature macro used by the top: RF_WB_PERF_EN.
package rf_wb_arbiter_pkg;

    typedef enum logic {
        PRIO_M = 1'b0,
        PRIO_A = 1'b1
    } prio_state_e;

    localparam int               RF_RW       = 4;
    localparam int               RF_DW       = 16;
    localparam logic [RF_RW-1:0] RF_ZERO_REG = 4'h0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_prio_fsm.sv
// Priority FSM for the writeback arbiter: M normally wins conflicts, A is
// promoted after STARVE_MAX consecutive lost conflict cycles.
module rf_wb_prio_fsm
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_valid,
    input  logic m_valid,
    input  logic a_grant,
    output logic prio_a
);

    localparam int            CW       = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

    prio_state_e   state;
    logic [CW-1:0] starve_cnt;

    // The promotion fires on the loss that brings the count to STARVE_MAX,
    // so the counter never has to hold a value above STARVE_MAX-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRIO_M;
            starve_cnt <= '0;
            prio_a     <= 1'b0;
        end else begin
            case (state)
                PRIO_M: begin
                    if (a_grant) begin
                        starve_cnt <= '0;
                    end else if (a_valid && m_valid) begin
                        if (starve_cnt >= CNT_LAST) begin
                            state      <= PRIO_A;
                            prio_a     <= 1'b1;
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end
                end
                PRIO_A: begin
                    if (a_grant) begin
                        state      <= PRIO_M;
                        prio_a     <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state      <= PRIO_M;
                    prio_a     <= 1'b0;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter in front of the register file write port.
// Define RF_WB_PERF_EN to add the perf_conflicts counter output.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int DW         = RF_DW,
    parameter int RW         = RF_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [RW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic [RW-1:0] m_reg,
    input  logic [DW-1:0] m_data,
`ifdef RF_WB_PERF_EN
    output logic [15:0]   perf_conflicts,
`endif
    output logic          rf_we,
    output logic [RW-1:0] rf_dst,
    output logic [DW-1:0] rf_data
);

    logic          prio_a;
    logic          a_grant;
    logic          m_grant;
    logic [RW-1:0] sel_reg;
    logic [DW-1:0] sel_data;
    logic          wr_p0;
    logic          we_p1;
    logic [RW-1:0] dst_p1;
    logic [DW-1:0] data_p1;

    rf_wb_prio_fsm #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_valid(a_valid),
        .m_valid(m_valid),
        .a_grant(a_grant),
        .prio_a (prio_a)
    );

    // Stage p0: combinational grant and winner select
    assign a_grant  = a_valid & (~m_valid | prio_a);
    assign m_grant  = m_valid & ~a_grant;
    assign a_ready  = a_grant;
    assign m_ready  = m_grant;
    assign sel_reg  = a_grant ? a_reg  : m_reg;
    assign sel_data = a_grant ? a_data : m_data;
    assign wr_p0    = (a_grant | m_grant) && (sel_reg != RW'(RF_ZERO_REG));

    // Stage p1: registered write toward the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1   <= 1'b0;
            dst_p1  <= '0;
            data_p1 <= '0;
        end else begin
            we_p1 <= wr_p0;
            if (wr_p0) begin
                dst_p1  <= sel_reg;
                data_p1 <= sel_data;
            end
        end
    end

    assign rf_we   = we_p1;
    assign rf_dst  = dst_p1;
    assign rf_data = data_p1;

`ifdef RF_WB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conflicts <= 16'd0;
        end else if (a_valid && m_valid) begin
            perf_conflicts <= sat_inc16(perf_conflicts);
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed requests push expected writes,
// a negedge monitor pops and compares whatever appears on rf_*.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, m_valid = 1'b0;
    logic [3:0]  a_reg = '0, m_reg = '0;
    logic [15:0] a_data = '0, m_data = '0;
    logic        a_ready, m_ready, rf_we;
    logic [3:0]  rf_dst;
    logic [15:0] rf_data;
`ifdef RF_WB_PERF_EN
    logic [15:0] perf_conflicts;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        time         t;
        logic [3:0]  r;
        logic [15:0] d;
    } exp_t;
    exp_t        sb[$];
    logic [15:0] rf_model[16];

    rf_wb_arbiter #(.STARVE_MAX(3), .DW(16), .RW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_reg  (a_reg),
        .a_data (a_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_reg  (m_reg),
        .m_data (m_data),
`ifdef RF_WB_PERF_EN
        .perf_conflicts(perf_conflicts),
`endif
        .rf_we  (rf_we),
        .rf_dst (rf_dst),
        .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One request cycle; called just after a rising edge. The expected ready
    // values are hand-computed by the caller.
    task automatic step(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                        input logic mv, input logic [3:0] mr, input logic [15:0] md,
                        input logic ea, input logic em, input string name);
        exp_t e;
        a_valid = av; a_reg = ar; a_data = ad;
        m_valid = mv; m_reg = mr; m_data = md;
        #2;
        chk({name, "_a_ready"}, {31'd0, a_ready}, {31'd0, ea});
        chk({name, "_m_ready"}, {31'd0, m_ready}, {31'd0, em});
        @(posedge clk);
        if (ea && ar != 4'd0) begin
            e.t = $time; e.r = ar; e.d = ad; sb.push_back(e);
        end
        if (em && mr != 4'd0) begin
            e.t = $time; e.r = mr; e.d = md; sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input string name);
        step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b0, name);
    endtask

    // Monitor: every presented write must match the oldest expected one,
    // exactly one half-period after the accepting edge.
    always @(negedge clk) begin
        if (rf_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {28'd0, rf_dst}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_latency", 32'($time - e.t), 32'd5);
                chk("wr_dst", {28'd0, rf_dst}, {28'd0, e.r});
                chk("wr_data", {16'd0, rf_data}, {16'd0, e.d});
            end
            rf_model[rf_dst] = rf_data;
        end
    end

    initial begin
        logic [9:0] a_wins;
        for (int i = 0; i < 16; i++) rf_model[i] = 16'd0;

        // Reset state
        #1;
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_dst", {28'd0, rf_dst}, 32'd0);
        chk("rst_data", {16'd0, rf_data}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // A alone: write R3=0x1234, then rf_we drops
        step(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0, "a_only");
        chk("a_only_we", {31'd0, rf_we}, 32'd1);
        idle("idle1");
        chk("a_only_we_drop", {31'd0, rf_we}, 32'd0);

        // Continuous conflict: M, M, M, A, M, M, M, A
        a_wins = 10'b00_1000_1000;
        for (int i = 0; i < 8; i++)
            step(1'b1, 4'd1, 16'hA000 + 16'(i), 1'b1, 4'd2, 16'hB000 + 16'(i),
                 a_wins[i], ~a_wins[i], $sformatf("conflict%0d", i));
        idle("idle2");

        // M writing R0: handshake completes, no register write
        step(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'hBEEF, 1'b0, 1'b1, "m_r0");
        chk("m_r0_we", {31'd0, rf_we}, 32'd0);
        idle("idle3");

        // Same destination R5: M wins first, A (held) goes next
        step(1'b1, 4'd5, 16'h0001, 1'b1, 4'd5, 16'h0002, 1'b0, 1'b1, "same_reg0");
        step(1'b1, 4'd5, 16'h0001, 1'b0, 4'd0, 16'd0, 1'b1, 1'b0, "same_reg1");
        idle("idle4");
        idle("idle5");
        chk("r5_final", {16'd0, rf_model[5]}, 32'h0000_0001);
        chk("r0_untouched", {16'd0, rf_model[0]}, 32'd0);

        // Drive FSM into PRIO_A, grant M alone, then reset mid-output
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'd1, 16'hC000 + 16'(i), 1'b1, 4'd2, 16'hD000 + 16'(i),
                 1'b0, 1'b1, $sformatf("prep%0d", i));
        step(1'b0, 4'd0, 16'd0, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b1, "m_in_prio_a");
        a_valid = 1'b0; m_valid = 1'b0;
        chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", {31'd0, rf_we}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // After reset the FSM is back in PRIO_M
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'd4, 16'hE000 + 16'(i), 1'b1, 4'd6, 16'hF000 + 16'(i),
                 a_wins[i], ~a_wins[i], $sformatf("post_rst%0d", i));
`ifdef RF_WB_PERF_EN
        chk("perf_conflicts", {16'd0, perf_conflicts}, 32'd10);
`endif
        idle("idle6");
        idle("idle7");
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
